mips32_pipeline: RTL and testbench

- 5-stage in-order 32-bit MIPS-style pipeline: IF, ID, EX, MEM, WB.
- Separate word-addressed instruction and data memories, plus a 32x32 register file, all held inside the block.
- Memories and register file are preloaded and inspected by hierarchical access: Inst_Mem, Data_Mem, Reg_File, PC, HALTED.
- Forwarding, a one-cycle load-use stall and branch flush make hazard-free code unnecessary.

---
 rtl/mips32_pipeline.sv | 232 +++++++++++++++++++++++
 tb/tb_mips32_pipeline.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_pipeline.sv
// Five-stage MIPS-style core with private instruction/data memories and register file; HALT raises halted.
// One instruction per cycle; a load-use pair costs one bubble, a taken branch or jump costs two cycles.
module mips32_pipeline #(
    parameter int IMEM_DEPTH = 1024,
    parameter int DMEM_DEPTH = 1024
) (
    input  logic clkP,
    input  logic rst_n,
    output logic halted
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    localparam logic [5:0] OP_MUL  = 6'b000010;
    localparam logic [5:0] OP_LW   = 6'b000110;
    localparam logic [5:0] OP_SW   = 6'b000111;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SUBI = 6'b001001;
    localparam logic [5:0] OP_BEQ  = 6'b001011;
    localparam logic [5:0] OP_BNE  = 6'b001100;
    localparam logic [5:0] OP_J    = 6'b001101;
    localparam logic [5:0] OP_ALU  = 6'b001110;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [3:0] {
        K_NOP, K_MUL, K_LW, K_SW, K_ADDI, K_SUBI, K_BEQ, K_BNE,
        K_J, K_OR, K_SUB, K_ADD, K_AND, K_SLT, K_HALT
    } kind_e;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
    } ifid_t;

    typedef struct packed {
        kind_e       kind;
        logic [4:0]  rs, rt, dest;
        logic        wr;
        logic [31:0] npc, a, b, imm;
        logic [25:0] target;
    } idex_t;

    typedef struct packed {
        kind_e       kind;
        logic [4:0]  dest;
        logic        wr;
        logic [31:0] alu, sdat;
    } exmem_t;

    typedef struct packed {
        logic [4:0]  dest;
        logic        wr;
        logic        halt;
        logic [31:0] res;
    } memwb_t;

    logic [31:0] Inst_Mem [IMEM_DEPTH];
    logic [31:0] Data_Mem [DMEM_DEPTH];
    logic [31:0] Reg_File [32];
    logic [31:0] PC;
    logic        HALTED;

    logic [31:0] pc_d;
    logic        halted_d;
    logic        fetch_stop_q, fetch_stop_d;
    ifid_t       ifid_q, ifid_d;
    idex_t       idex_q, idex_d;
    exmem_t      exmem_q, exmem_d;
    memwb_t      memwb_q, memwb_d;

    kind_e       id_kind;
    idex_t       id_pkt;
    logic        id_uses_rs, id_uses_rt, load_use;
    logic [31:0] ex_a, ex_b, ex_alu, ex_target;
    logic        ex_taken;
    logic [31:0] mem_rdata;

    function automatic kind_e decode(input logic [5:0] op, input logic [10:0] funct);
        kind_e k;
        k = K_NOP;
        case (op)
            OP_MUL:  k = K_MUL;
            OP_LW:   k = K_LW;
            OP_SW:   k = K_SW;
            OP_ADDI: k = K_ADDI;
            OP_SUBI: k = K_SUBI;
            OP_BEQ:  k = K_BEQ;
            OP_BNE:  k = K_BNE;
            OP_J:    k = K_J;
            OP_HALT: k = K_HALT;
            OP_ALU: begin
                case (funct)
                    11'd0:   k = K_OR;
                    11'd1:   k = K_SUB;
                    11'd2:   k = K_ADD;
                    11'd3:   k = K_AND;
                    11'd4:   k = K_SLT;
                    default: k = K_NOP;
                endcase
            end
            default: k = K_NOP;
        endcase
        return k;
    endfunction

    // ID: decode, register read with write-through from WB, load-use detection.
    always_comb begin
        id_kind    = decode(ifid_q.ir[31:26], ifid_q.ir[10:0]);
        id_uses_rs = id_kind inside {K_MUL, K_LW, K_SW, K_ADDI, K_SUBI, K_BEQ, K_BNE,
                                     K_OR, K_SUB, K_ADD, K_AND, K_SLT};
        id_uses_rt = id_kind inside {K_MUL, K_SW, K_BEQ, K_BNE, K_OR, K_SUB, K_ADD, K_AND, K_SLT};

        id_pkt        = '0;
        id_pkt.kind   = id_kind;
        id_pkt.rs     = ifid_q.ir[25:21];
        id_pkt.rt     = ifid_q.ir[20:16];
        id_pkt.dest   = (id_kind inside {K_MUL, K_OR, K_SUB, K_ADD, K_AND, K_SLT})
                        ? ifid_q.ir[15:11] : ifid_q.ir[20:16];
        id_pkt.wr     = (id_kind inside {K_MUL, K_LW, K_ADDI, K_SUBI, K_OR, K_SUB, K_ADD, K_AND, K_SLT})
                        && (id_pkt.dest != 5'd0);
        id_pkt.npc    = ifid_q.npc;
        id_pkt.imm    = {{16{ifid_q.ir[15]}}, ifid_q.ir[15:0]};
        id_pkt.target = ifid_q.ir[25:0];

        id_pkt.a = (id_pkt.rs == 5'd0) ? 32'd0 : Reg_File[id_pkt.rs];
        id_pkt.b = (id_pkt.rt == 5'd0) ? 32'd0 : Reg_File[id_pkt.rt];
        if (memwb_q.wr && memwb_q.dest == id_pkt.rs) id_pkt.a = memwb_q.res;
        if (memwb_q.wr && memwb_q.dest == id_pkt.rt) id_pkt.b = memwb_q.res;

        load_use = (idex_q.kind == K_LW) && idex_q.wr &&
                   ((id_uses_rs && id_pkt.rs == idex_q.dest) ||
                    (id_uses_rt && id_pkt.rt == idex_q.dest));
    end

    // EX: the EX/MEM producer is younger than MEM/WB so it is checked first; wr is never set for R0.
    always_comb begin
        ex_a = idex_q.a;
        if (exmem_q.wr && exmem_q.kind != K_LW && exmem_q.dest == idex_q.rs) ex_a = exmem_q.alu;
        else if (memwb_q.wr && memwb_q.dest == idex_q.rs)                     ex_a = memwb_q.res;

        ex_b = idex_q.b;
        if (exmem_q.wr && exmem_q.kind != K_LW && exmem_q.dest == idex_q.rt) ex_b = exmem_q.alu;
        else if (memwb_q.wr && memwb_q.dest == idex_q.rt)                     ex_b = memwb_q.res;

        case (idex_q.kind)
            K_MUL:               ex_alu = ex_a * ex_b;
            K_LW, K_SW, K_ADDI:  ex_alu = ex_a + idex_q.imm;
            K_SUBI:              ex_alu = ex_a - idex_q.imm;
            K_OR:                ex_alu = ex_a | ex_b;
            K_SUB:               ex_alu = ex_a - ex_b;
            K_ADD:               ex_alu = ex_a + ex_b;
            K_AND:               ex_alu = ex_a & ex_b;
            K_SLT:               ex_alu = {31'd0, $signed(ex_a) < $signed(ex_b)};
            default:             ex_alu = 32'd0;
        endcase

        ex_taken  = (idex_q.kind == K_BEQ && ex_a == ex_b) ||
                    (idex_q.kind == K_BNE && ex_a != ex_b) ||
                    (idex_q.kind == K_J);
        ex_target = (idex_q.kind == K_J) ? {idex_q.npc[31:26], idex_q.target}
                                         : idex_q.npc + idex_q.imm;

        exmem_d      = '0;
        exmem_d.kind = idex_q.kind;
        exmem_d.dest = idex_q.dest;
        exmem_d.wr   = idex_q.wr;
        exmem_d.alu  = ex_alu;
        exmem_d.sdat = ex_b;
    end

    always_comb begin
        mem_rdata    = Data_Mem[exmem_q.alu[DAW-1:0]];
        memwb_d      = '0;
        memwb_d.dest = exmem_q.dest;
        memwb_d.wr   = exmem_q.wr;
        memwb_d.halt = (exmem_q.kind == K_HALT);
        memwb_d.res  = (exmem_q.kind == K_LW) ? mem_rdata : exmem_q.alu;
        halted_d     = HALTED | memwb_q.halt;
    end

    // Priority: taken-branch flush, then load-use hold, then HALT fetch stop, else sequential fetch.
    always_comb begin
        pc_d         = PC;
        ifid_d       = ifid_q;
        idex_d       = id_pkt;
        fetch_stop_d = fetch_stop_q;
        if (ex_taken) begin
            pc_d   = ex_target;
            ifid_d = '0;
            idex_d = '0;
        end else if (load_use) begin
            idex_d = '0;
        end else if (fetch_stop_q || id_kind == K_HALT) begin
            ifid_d       = '0;
            fetch_stop_d = 1'b1;
        end else begin
            pc_d       = PC + 32'd1;
            ifid_d.ir  = Inst_Mem[PC[IAW-1:0]];
            ifid_d.npc = PC + 32'd1;
        end
    end

    always_ff @(posedge clkP) begin
        if (!rst_n) begin
            PC           <= '0;
            HALTED       <= 1'b0;
            fetch_stop_q <= 1'b0;
            ifid_q       <= '0;
            idex_q       <= '0;
            exmem_q      <= '0;
            memwb_q      <= '0;
        end else begin
            PC           <= pc_d;
            HALTED       <= halted_d;
            fetch_stop_q <= fetch_stop_d;
            ifid_q       <= ifid_d;
            idex_q       <= idex_d;
            exmem_q      <= exmem_d;
            memwb_q      <= memwb_d;
        end
    end

    // Storage is never reset; writes are suppressed during reset and once halted.
    always_ff @(posedge clkP) begin
        if (rst_n && !HALTED) begin
            if (exmem_q.kind == K_SW) Data_Mem[exmem_q.alu[DAW-1:0]] <= exmem_q.sdat;
            if (memwb_q.wr)           Reg_File[memwb_q.dest]         <= memwb_q.res;
        end
    end

    assign halted = HALTED;
endmodule

// File: tb/tb_mips32_pipeline.sv
// Directed bench for mips32_pipeline: preloads programs hierarchically and checks registers, memory and timing.
module tb_mips32_pipeline;
    localparam int BOUND = 3000;

    logic clkP = 1'b0;
    logic rst_n = 1'b0;
    logic halted;
    int   n_checks = 0;
    int   n_pass = 0;
    int   fib_cycles = 0;

    mips32_pipeline #(.IMEM_DEPTH(1024), .DMEM_DEPTH(1024)) dut (
        .clkP  (clkP),
        .rst_n (rst_n),
        .halted(halted)
    );

    always #5 clkP = ~clkP;

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [10:0] funct);
        return {op, rs, rt, rd, funct};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] target);
        return {6'b001101, target};
    endfunction

    localparam logic [31:0] HALT_I = 32'hFC00_0000;

    task automatic hold_reset();
        @(negedge clkP);
        rst_n = 1'b0;
        @(posedge clkP);
        #1;
    endtask

    task automatic clear_state();
        for (int i = 0; i < 1024; i++) begin
            dut.Inst_Mem[i] = 32'd0;
            dut.Data_Mem[i] = 32'd0;
        end
        for (int i = 0; i < 32; i++) dut.Reg_File[i] = 32'd0;
    endtask

    // Releases reset and counts rising edges until halted (or the bound expires).
    task automatic run_to_halt(output int cycles);
        @(negedge clkP);
        rst_n  = 1'b1;
        cycles = 0;
        while (cycles < BOUND) begin
            @(posedge clkP);
            #1;
            cycles++;
            if (halted) break;
        end
    endtask

    task automatic load_fib();
        clear_state();
        dut.Data_Mem[1] = 32'd7;
        dut.Data_Mem[2] = 32'd1;
        dut.Data_Mem[4] = 32'd9;
        dut.Inst_Mem[0]  = enc_i(6'b001000, 5'd0, 5'd1, 16'd0);
        dut.Inst_Mem[1]  = enc_i(6'b000110, 5'd0, 5'd2, 16'd2);
        dut.Inst_Mem[2]  = enc_i(6'b000110, 5'd0, 5'd3, 16'd4);
        dut.Inst_Mem[3]  = enc_i(6'b001011, 5'd3, 5'd0, 16'd5);
        dut.Inst_Mem[4]  = enc_r(6'b001110, 5'd2, 5'd0, 5'd4, 11'd0);
        dut.Inst_Mem[5]  = enc_r(6'b001110, 5'd1, 5'd2, 5'd2, 11'd2);
        dut.Inst_Mem[6]  = enc_r(6'b001110, 5'd4, 5'd0, 5'd1, 11'd0);
        dut.Inst_Mem[7]  = enc_i(6'b001001, 5'd3, 5'd3, 16'd1);
        dut.Inst_Mem[8]  = enc_j(26'd3);
        dut.Inst_Mem[9]  = enc_i(6'b000110, 5'd0, 5'd5, 16'd1);
        dut.Inst_Mem[10] = enc_i(6'b001000, 5'd0, 5'd6, 16'd1);
        dut.Inst_Mem[11] = enc_i(6'b001011, 5'd0, 5'd5, 16'd3);
        dut.Inst_Mem[12] = enc_r(6'b000010, 5'd5, 5'd6, 5'd6, 11'd0);
        dut.Inst_Mem[13] = enc_i(6'b001001, 5'd5, 5'd5, 16'd1);
        dut.Inst_Mem[14] = enc_j(26'd11);
        dut.Inst_Mem[15] = HALT_I;
    endtask

    task automatic test_reset();
        int cyc;
        hold_reset();
        clear_state();
        dut.Inst_Mem[0] = HALT_I;
        run_to_halt(cyc);
        n_checks++;
        if (cyc !== 5 || halted !== 1'b1) $display("FAIL reset_halt_only: cycles %0d halted %0b, want 5/1", cyc, halted);
        else n_pass++;
        n_checks++;
        if (dut.PC !== 32'd1) $display("FAIL reset_pre_pc: got %0d want 1", dut.PC);
        else n_pass++;
        hold_reset();
        n_checks++;
        if (dut.PC !== 32'd0) $display("FAIL reset_pc: got %0d want 0", dut.PC);
        else n_pass++;
        n_checks++;
        if (halted !== 1'b0 || dut.HALTED !== 1'b0) $display("FAIL reset_halted: got %0b/%0b want 0", halted, dut.HALTED);
        else n_pass++;
    endtask

    task automatic check_fib_results(input string tag);
        int exp_r[7];
        exp_r = '{0, 34, 55, 0, 34, 0, 5040};
        n_checks++;
        if (halted !== 1'b1) $display("FAIL %s_halted: got %0b want 1", tag, halted);
        else n_pass++;
        for (int i = 1; i < 7; i++) begin
            n_checks++;
            if (dut.Reg_File[i] !== exp_r[i]) $display("FAIL %s_r%0d: got %0d want %0d", tag, i, dut.Reg_File[i], exp_r[i]);
            else n_pass++;
        end
        n_checks++;
        if (dut.PC !== 32'd16) $display("FAIL %s_pc: got %0d want 16", tag, dut.PC);
        else n_pass++;
    endtask

    task automatic test_fib();
        hold_reset();
        load_fib();
        run_to_halt(fib_cycles);
        check_fib_results("fib");
        repeat (5) @(posedge clkP);
        #1;
        n_checks++;
        if (dut.PC !== 32'd16 || halted !== 1'b1 || dut.Reg_File[6] !== 32'd5040)
            $display("FAIL fib_frozen: pc %0d halted %0b r6 %0d, want 16/1/5040", dut.PC, halted, dut.Reg_File[6]);
        else n_pass++;
    endtask

    task automatic test_forwarding();
        int cyc;
        hold_reset();
        clear_state();
        dut.Inst_Mem[0] = enc_i(6'b001000, 5'd0, 5'd1, 16'd5);
        dut.Inst_Mem[1] = enc_r(6'b001110, 5'd1, 5'd1, 5'd2, 11'd2);
        dut.Inst_Mem[2] = HALT_I;
        run_to_halt(cyc);
        n_checks++;
        if (dut.Reg_File[2] !== 32'd10 || dut.Reg_File[1] !== 32'd5)
            $display("FAIL fwd_value: r1 %0d r2 %0d want 5/10", dut.Reg_File[1], dut.Reg_File[2]);
        else n_pass++;
        n_checks++;
        if (cyc !== 7) $display("FAIL fwd_no_stall: cycles %0d want 7", cyc);
        else n_pass++;
    endtask

    task automatic test_load_use();
        int cyc;
        hold_reset();
        clear_state();
        dut.Data_Mem[4] = 32'd9;
        dut.Inst_Mem[0] = enc_i(6'b000110, 5'd0, 5'd3, 16'd4);
        dut.Inst_Mem[1] = enc_i(6'b001001, 5'd3, 5'd4, 16'd1);
        dut.Inst_Mem[2] = HALT_I;
        run_to_halt(cyc);
        n_checks++;
        if (dut.Reg_File[4] !== 32'd8 || dut.Reg_File[3] !== 32'd9)
            $display("FAIL lu_value: r3 %0d r4 %0d want 9/8", dut.Reg_File[3], dut.Reg_File[4]);
        else n_pass++;
        n_checks++;
        if (cyc !== 8) $display("FAIL lu_one_bubble: cycles %0d want 8", cyc);
        else n_pass++;
    endtask

    task automatic test_branch_flush();
        int cyc;
        hold_reset();
        clear_state();
        dut.Inst_Mem[0] = enc_i(6'b001011, 5'd0, 5'd0, 16'd2);
        dut.Inst_Mem[1] = enc_i(6'b001000, 5'd0, 5'd7, 16'd1);
        dut.Inst_Mem[2] = enc_i(6'b001000, 5'd0, 5'd8, 16'd1);
        dut.Inst_Mem[3] = enc_i(6'b001000, 5'd0, 5'd9, 16'd3);
        dut.Inst_Mem[4] = HALT_I;
        run_to_halt(cyc);
        n_checks++;
        if (dut.Reg_File[7] !== 32'd0 || dut.Reg_File[8] !== 32'd0)
            $display("FAIL br_flush: r7 %0d r8 %0d want 0/0", dut.Reg_File[7], dut.Reg_File[8]);
        else n_pass++;
        n_checks++;
        if (dut.Reg_File[9] !== 32'd3) $display("FAIL br_target: r9 %0d want 3", dut.Reg_File[9]);
        else n_pass++;
        n_checks++;
        if (cyc !== 9) $display("FAIL br_penalty: cycles %0d want 9", cyc);
        else n_pass++;
    endtask

    task automatic test_r0_store();
        int cyc;
        hold_reset();
        clear_state();
        dut.Inst_Mem[0] = enc_i(6'b001000, 5'd0, 5'd0, 16'd5);
        dut.Inst_Mem[1] = enc_r(6'b001110, 5'd0, 5'd0, 5'd1, 11'd2);
        dut.Inst_Mem[2] = enc_i(6'b001000, 5'd0, 5'd2, 16'd11);
        dut.Inst_Mem[3] = enc_i(6'b000111, 5'd0, 5'd2, 16'd6);
        dut.Inst_Mem[4] = enc_i(6'b000110, 5'd0, 5'd3, 16'd6);
        dut.Inst_Mem[5] = HALT_I;
        run_to_halt(cyc);
        n_checks++;
        if (dut.Reg_File[1] !== 32'd0 || dut.Reg_File[0] !== 32'd0)
            $display("FAIL r0_discard: r0 %0d r1 %0d want 0/0", dut.Reg_File[0], dut.Reg_File[1]);
        else n_pass++;
        n_checks++;
        if (dut.Data_Mem[6] !== 32'd11) $display("FAIL sw_mem6: got %0d want 11", dut.Data_Mem[6]);
        else n_pass++;
        n_checks++;
        if (dut.Reg_File[3] !== 32'd11 || halted !== 1'b1)
            $display("FAIL lw_after_sw: r3 %0d halted %0b want 11/1", dut.Reg_File[3], halted);
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        logic [31:0] snap [32];
        int diffs;
        int cyc;
        hold_reset();
        load_fib();
        @(negedge clkP);
        rst_n = 1'b1;
        repeat (40) @(posedge clkP);
        #1;
        n_checks++;
        if (halted !== 1'b0) $display("FAIL mid_not_done: halted %0b want 0", halted);
        else n_pass++;
        for (int i = 0; i < 32; i++) snap[i] = dut.Reg_File[i];
        @(negedge clkP);
        rst_n = 1'b0;
        @(posedge clkP);
        #1;
        diffs = 0;
        for (int i = 0; i < 32; i++) if (dut.Reg_File[i] !== snap[i]) diffs++;
        n_checks++;
        if (diffs !== 0) $display("FAIL mid_no_writes: %0d registers changed, want 0", diffs);
        else n_pass++;
        n_checks++;
        if (dut.PC !== 32'd0 || halted !== 1'b0) $display("FAIL mid_reset_state: pc %0d halted %0b want 0/0", dut.PC, halted);
        else n_pass++;
        for (int i = 0; i < 32; i++) dut.Reg_File[i] = 32'd0;
        run_to_halt(cyc);
        check_fib_results("rerun");
        n_checks++;
        if (cyc !== fib_cycles) $display("FAIL rerun_cycles: got %0d want %0d", cyc, fib_cycles);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fib();
        test_forwarding();
        test_load_use();
        test_branch_flush();
        test_r0_store();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
